// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: SPI-slave (mode 0) configuration controller.
// Synchronises sclk/copi/ncs into clk and decodes 16-bit write frames
// {rw, addr[6:0], data[7:0]}. Each accepted frame commits its data into one
// of five configuration registers. The PWM datapath reads those registers.
module spi_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic       frame_err
);

  localparam int         FW    = $clog2(SYNC_STAGES + 2);
  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  // Synchroniser chains; bit 0 takes the raw pin, the top bit is the synced value
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;

  // One extra copy for edge detection, plus the registered edge pulses
  logic sclk_prev_q, sclk_prev_d;
  logic copi_prev_q, copi_prev_d;
  logic ncs_prev_q,  ncs_prev_d;
  logic sclk_rise_q, sclk_rise_d;
  logic ncs_rise_q,  ncs_rise_d;
  logic ncs_fall_q,  ncs_fall_d;

  // After reset the ncs chain holds its reset value (1). If the pin is still
  // low, that value would drain out as a fake falling edge. Falling edges are
  // accepted only once ncs has been seen high with a fully refreshed chain.
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          armed_q, armed_d;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [15:0]     sh_q, sh_d;
  logic [4:0][7:0] cfg_q, cfg_d;
  logic [6:0]      wr_addr_q, wr_addr_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic            frame_err_q, frame_err_d;

  logic sclk_last, copi_last, ncs_last, flush_done;

  assign sclk_last  = sclk_sync_q[SYNC_STAGES-1];
  assign copi_last  = copi_sync_q[SYNC_STAGES-1];
  assign ncs_last   = ncs_sync_q[SYNC_STAGES-1];
  assign flush_done = (flush_cnt_q == FW'(SYNC_STAGES + 1));

  // Synchroniser shifting, edge detection and post-reset arming
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  ncs};
    sclk_prev_d = sclk_last;
    copi_prev_d = copi_last;
    ncs_prev_d  = ncs_last;
    sclk_rise_d = sclk_last & ~sclk_prev_q;
    ncs_rise_d  = ncs_last  & ~ncs_prev_q;
    ncs_fall_d  = armed_q & ~ncs_last & ncs_prev_q;
    flush_cnt_d = flush_done ? flush_cnt_q : flush_cnt_q + FW'(1);
    armed_d     = armed_q | (flush_done & ncs_last & ncs_prev_q);
  end

  // Frame FSM: shift bits in, then decide commit / reject / ignore at ncs rise
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    cfg_d       = cfg_q;
    wr_addr_d   = wr_addr_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      SHIFT: begin
        if (ncs_rise_q) begin
          if (cnt_q != 5'd16 || sh_q[14:8] > MAX_A) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (sh_q[15]) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
          end
        end else if (sclk_rise_q && !ncs_prev_q) begin
          sh_d = {sh_q[14:0], copi_prev_q};
          // Saturate at 17 so an over-long frame stays distinguishable
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      COMMIT: begin
        wr_strobe_d = 1'b1;
        wr_addr_d   = sh_q[14:8];
        case (sh_q[14:8])
          7'd0:    cfg_d[0] = sh_q[7:0];
          7'd1:    cfg_d[1] = sh_q[7:0];
          7'd2:    cfg_d[2] = sh_q[7:0];
          7'd3:    cfg_d[3] = sh_q[7:0];
          7'd4:    cfg_d[4] = sh_q[7:0];
          default: ;
        endcase
        if (ncs_fall_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      copi_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      sclk_rise_q <= 1'b0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
      flush_cnt_q <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      cfg_q       <= '0;
      wr_addr_q   <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      copi_prev_q <= copi_prev_d;
      ncs_prev_q  <= ncs_prev_d;
      sclk_rise_q <= sclk_rise_d;
      ncs_rise_q  <= ncs_rise_d;
      ncs_fall_q  <= ncs_fall_d;
      flush_cnt_q <= flush_cnt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      cfg_q       <= cfg_d;
      wr_addr_q   <= wr_addr_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign en_reg_out_7_0  = cfg_q[0];
  assign en_reg_out_15_8 = cfg_q[1];
  assign en_reg_pwm_7_0  = cfg_q[2];
  assign en_reg_pwm_15_8 = cfg_q[3];
  assign pwm_duty_cycle  = cfg_q[4];
  assign wr_strobe       = wr_strobe_q;
  assign wr_addr         = wr_addr_q;
  assign frame_err       = frame_err_q;

endmodule

// File: doc/spi_cfg_ctrl.md
Name: spi_cfg_ctrl

Overview:
SPI-slave configuration controller for the user project. It takes the external SPI pins (sclk, copi, ncs) from the dedicated inputs and synchronises them into clk. It decodes 16-bit write frames and commits them into the configuration registers that drive output enables, PWM enables and the PWM duty cycle. The block is the sole writer of that register bank. The PWM datapath reads the registers directly.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).
MAX_ADDR, 4, highest valid register address. Frames addressing above this are rejected.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
sclk  in  1  SPI clock, asynchronous to clk. Mode 0: sample on rising edge.
copi  in  1  SPI data in, MSB first, asynchronous.
ncs  in  1  SPI chip select, active-low, asynchronous.
en_reg_out_7_0  out  8  register 0x00.
en_reg_out_15_8  out  8  register 0x01.
en_reg_pwm_7_0  out  8  register 0x02.
en_reg_pwm_15_8  out  8  register 0x03.
pwm_duty_cycle  out  8  register 0x04.
wr_strobe  out  1  one-cycle pulse when a register is updated.
wr_addr  out  7  address of the last committed write. Valid while wr_strobe is high and held afterwards.
frame_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (rst high at a clk rising edge):
  - All five registers, wr_addr, wr_strobe and frame_err go to 0.
  - FSM goes to IDLE; bit counter and shift register are cleared.
  - ncs synchroniser stages reset to 1; sclk synchroniser stages reset to 0. This prevents false edges after reset.
- Synchronisation: each of sclk, copi and ncs passes through SYNC_STAGES flip-flops.
  - Edge detection compares the last sync stage with one extra registered copy.
  - Legal input timing: sclk high and low phases are each ≥ 4 clk periods; ncs setup/hold to sclk edges is ≥ 4 clk periods.
- Frame format: bit15 = R/W (1 = write), bits14:8 = addr, bits7:0 = data.
- FSM states:
  - IDLE → SHIFT on a synced ncs falling edge. Counter and shift register clear.
  - SHIFT, on each synced sclk rising edge while ncs is low: shift the synced copi into the LSB and increment the counter. The counter saturates at 17, so "more than 16 bits" is remembered.
  - SHIFT → COMMIT on a synced ncs rising edge when count == 16, R/W == 1 and addr ≤ MAX_ADDR.
  - SHIFT → IDLE on a synced ncs rising edge when count ≠ 16 or addr > MAX_ADDR. frame_err pulses for 1 cycle; no register changes.
  - SHIFT → IDLE on a synced ncs rising edge with count == 16 and R/W == 0 (read): silently ignored, no error, no write.
  - COMMIT lasts exactly 1 cycle. At its exit edge the register at addr loads data, wr_addr loads addr and wr_strobe pulses high for 1 cycle. Next state is IDLE, or SHIFT if a synced ncs falling edge is detected in the same cycle.
- Latency: the register value and wr_strobe are visible SYNC_STAGES+3 clk edges after the first clk edge that samples raw ncs high.
- sclk edges while ncs is high, or in IDLE, are ignored.
- frame_err and wr_strobe are never high in the same cycle.
- Reset mid-frame aborts the frame with no write. If ncs is still low when rst deasserts, the controller stays in IDLE until a fresh ncs falling edge; the remainder of the aborted frame is ignored.
- Registers hold their value indefinitely between writes. No read-back path exists; copi data is never echoed.

Test Plan:
- Reset: assert rst 2 cycles → all registers 0x00, wr_strobe = 0, frame_err = 0, FSM IDLE.
- Valid write: frame 0x84_80 (write, addr 0x04, data 0x80) → pwm_duty_cycle = 0x80 within SYNC_STAGES+3 cycles of ncs rising; wr_strobe pulses exactly 1 cycle with wr_addr = 0x04; all other registers unchanged.
- All addresses: write 0xF0, 0x0F, 0xAA, 0x55, 0xFF to addr 0–4 in back-to-back frames (ncs high 8 clk between frames) → each register holds its own value; exactly 5 wr_strobe pulses.
- Rejections:
  - addr 0x05 with data 0x12 → frame_err 1 pulse, no register change.
  - Read frame 0x00_34 → no write, no frame_err.
- Bit count: 15-bit frame, then 17-bit frame → frame_err pulses twice, registers unchanged.
- Mid-frame reset: assert rst after 9 bits of 0x81_3C; release rst with ncs low; finish the frame → en_reg_out_15_8 stays 0x00. A following full frame 0x81_3C → en_reg_out_15_8 = 0x3C.
